// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data-memory sequencer.
package mem_ctrl_pkg;

    localparam int unsigned DMEM_DATA_W  = 32;
    localparam int unsigned DMEM_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } dmem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog counter for data-memory accesses; tc flags the TIMEOUT-th enabled cycle.
module mem_timeout_ctr
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && (cnt_q == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer onto a valid/ready data-memory port with watchdog abort.
// Optional posted-store buffer enabled by defining DMEM_STORE_POST_EN.
module dmem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = DMEM_DATA_W,
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead_EXMEM_out,
    input  logic              memWrite_EXMEM_out,
    input  logic [DATA_W-1:0] addr_EXMEM_out,
    input  logic [3:0]        byteEn_EXMEM_out,
    input  logic [DATA_W-1:0] RegData2_after_forward_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_mem,
    output logic [DATA_W-1:0] memReadRst,
    output logic              dmem_err
);

`ifdef DMEM_STORE_POST_EN
    localparam bit POST_EN = 1'b1;
`else
    localparam bit POST_EN = 1'b0;
`endif

    dmem_state_t       state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              posted_q, posted_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [3:0]        be_q, be_d;
    logic              stall_c;
    logic              ctr_clr, ctr_en, ctr_tc;
    logic              mem_op;

    assign mem_op = memRead_EXMEM_out | memWrite_EXMEM_out;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (ctr_en),
        .tc  (ctr_tc)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        posted_d = posted_q;
        stall_c  = 1'b0;
        ctr_clr  = 1'b1;
        ctr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                posted_d = 1'b0;
                if (mem_op) begin
                    addr_d  = addr_EXMEM_out;
                    wdata_d = RegData2_after_forward_M;
                    be_d    = byteEn_EXMEM_out;
                    we_d    = !memRead_EXMEM_out;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                    if (POST_EN && !memRead_EXMEM_out) begin
                        posted_d = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                ctr_clr = 1'b0;
                ctr_en  = 1'b1;
                // A posted store only holds back whatever op has since reached MEM.
                stall_c = posted_q ? mem_op : 1'b1;
                if (dmem_ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else if (dmem_rvalid) begin
                        rdata_d = dmem_rdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (ctr_tc) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    if (!posted_q) begin
                        rdata_d = '0;
                    end
                end
            end

            ST_WAIT: begin
                ctr_clr = 1'b0;
                ctr_en  = 1'b1;
                stall_c = 1'b1;
                if (dmem_rvalid) begin
                    rdata_d = dmem_rdata;
                    state_d = ST_DONE;
                end else if (ctr_tc) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                stall_c = posted_q ? mem_op : 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            posted_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            err_q    <= err_d;
            posted_q <= posted_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            be_q     <= be_d;
        end
    end

    // Gated so every output reads 0 for the whole reset pulse, even with an op in MEM.
    assign stall_mem  = stall_c & ~rst;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign memReadRst = rdata_q;
    assign dmem_err   = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomised bench for dmem_access_ctrl against a transaction-level latency model.
module tb_dmem_access_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  byteEn;
    logic        ready, rvalid;
    logic        dmem_req, dmem_we, stall_mem, dmem_err;
    logic [31:0] dmem_addr, dmem_wdata, memReadRst;
    logic [3:0]  dmem_be;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_rst;

    dmem_access_ctrl #(.DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .memRead_EXMEM_out        (memRead),
        .memWrite_EXMEM_out       (memWrite),
        .addr_EXMEM_out           (addr),
        .byteEn_EXMEM_out         (byteEn),
        .RegData2_after_forward_M (wdata),
        .dmem_req                 (dmem_req),
        .dmem_we                  (dmem_we),
        .dmem_addr                (dmem_addr),
        .dmem_wdata               (dmem_wdata),
        .dmem_be                  (dmem_be),
        .dmem_ready               (ready),
        .dmem_rvalid              (rvalid),
        .dmem_rdata               (rdata),
        .stall_mem                (stall_mem),
        .memReadRst               (memReadRst),
        .dmem_err                 (dmem_err)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Idle pipeline cycles with junk on the response channel; nothing may change.
    task automatic idle_cycles(input int n);
        memRead  = 1'b0;
        memWrite = 1'b0;
        for (int i = 0; i < n; i++) begin
            ready  = 1'($urandom_range(0, 1));
            rvalid = 1'($urandom_range(0, 1));
            rdata  = $urandom;
            #1;
            chk_eq("idle_stall", 64'(stall_mem), 64'd0);
            chk_eq("idle_req", 64'(dmem_req), 64'd0);
            chk_eq("idle_err", 64'(dmem_err), 64'd0);
            chk_eq("idle_rst_hold", 64'(memReadRst), 64'(model_rst));
            @(negedge clk);
        end
        ready  = 1'b0;
        rvalid = 1'b0;
    endtask

    // One access. a = REQ cycle on which ready is given (0 = never);
    // w = WAIT cycle on which rvalid arrives (0 = together with ready).
    task automatic do_op(input bit ld, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [3:0] be, input int a, input int w, input logic [31:0] rd);
        int total, exp_stall, exp_req, stall_n, req_n, wait_n, bad;
        bit timeout, accepted, fin;
        total     = (a == 0) ? 1000 : (ld ? a + w : a);
        timeout   = total > TMO;
        exp_stall = 1 + (timeout ? TMO : total);
        exp_req   = (a == 0 || a > TMO) ? TMO : a;
        stall_n = 0; req_n = 0; wait_n = 0; bad = 0;
        accepted = 1'b0; fin = 1'b0;
        memRead  = ld;
        memWrite = ld ? 1'($urandom_range(0, 1)) : 1'b1;
        addr = ad; wdata = wd; byteEn = be;
        for (int c = 0; c < 60 && !fin; c++) begin
            #1;
            if (!stall_mem) begin
                fin = 1'b1;
            end else begin
                stall_n++;
                ready  = 1'b0;
                rvalid = 1'b0;
                rdata  = $urandom;
                if (dmem_req) begin
                    req_n++;
                    if (dmem_addr !== ad || dmem_wdata !== wd || dmem_be !== be ||
                        dmem_we !== !ld) bad++;
                    if (req_n == a) begin
                        ready = 1'b1;
                        accepted = 1'b1;
                        if (ld && w == 0) begin
                            rvalid = 1'b1;
                            rdata  = rd;
                        end
                    end
                end else if (accepted) begin
                    wait_n++;
                    if (wait_n == w) begin
                        rvalid = 1'b1;
                        rdata  = rd;
                    end
                end else begin
                    rvalid = 1'($urandom_range(0, 1));
                end
                if (c > 0) begin
                    addr = $urandom; wdata = $urandom; byteEn = 4'($urandom);
                end
                @(negedge clk);
            end
        end
        if (ld) model_rst = timeout ? 32'h0 : rd;
        else if (timeout) model_rst = 32'h0;
        chk_eq("op_completes", 64'(fin), 64'd1);
        chk_eq("stall_cycles", 64'(stall_n), 64'(exp_stall));
        chk_eq("req_cycles", 64'(req_n), 64'(exp_req));
        chk_eq("req_fields_stable", 64'(bad), 64'd0);
        chk_eq("done_err", 64'(dmem_err), 64'(timeout));
        chk_eq("done_req_low", 64'(dmem_req), 64'd0);
        chk_eq("done_rdata", 64'(memReadRst), 64'(model_rst));
        memRead = 1'b0; memWrite = 1'b0; ready = 1'b0; rvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        memRead = 1'b0; memWrite = 1'b0; addr = '0; wdata = '0; byteEn = '0;
        ready = 1'b0; rvalid = 1'b0; rdata = '0;
        model_rst = 32'h0;
        #1;
        chk_eq("reset_ctrl", 64'({dmem_req, dmem_we, dmem_err, stall_mem}), 64'd0);
        chk_eq("reset_rdata", 64'(memReadRst), 64'd0);
        chk_eq("reset_addr", 64'(dmem_addr), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_op(1'b1, 32'h100, 32'h0, 4'hF, 1, 0, 32'hDEADBEEF);
`ifndef DMEM_STORE_POST_EN
        do_op(1'b0, 32'h200, 32'h12345678, 4'hF, 4, 0, 32'h0);
`endif
        idle_cycles(3);
        do_op(1'b1, 32'h104, 32'h0, 4'hF, 1, 6, 32'hCAFEF00D);
        do_op(1'b1, 32'h108, 32'h0, 4'hF, 0, 0, 32'h11111111);
        idle_cycles(1);
        do_op(1'b1, 32'h10C, 32'h0, 4'h3, 3, 5, 32'h22222222);
        do_op(1'b1, 32'h110, 32'h0, 4'hC, 3, 6, 32'h33333333);
        do_op(1'b1, 32'h114, 32'h0, 4'hF, 8, 0, 32'h44444444);

        // Reset while waiting for read data
        memRead = 1'b1; addr = 32'h300; byteEn = 4'hF;
        #1; @(negedge clk);
        ready = 1'b1;
        #1; @(negedge clk);
        ready = 1'b0;
        #1; @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_eq("rst_async_ctrl", 64'({dmem_req, dmem_we, dmem_err, stall_mem}), 64'd0);
        chk_eq("rst_async_rdata", 64'(memReadRst), 64'd0);
        chk_eq("rst_async_fields", 64'({dmem_addr, dmem_be}), 64'd0);
        memRead = 1'b0;
        rvalid = 1'b1; rdata = 32'hBAD0BAD0;
        @(negedge clk);
        rst = 1'b0;
        model_rst = 32'h0;
        #1;
        rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        chk_eq("stale_rvalid_ignored", 64'(memReadRst), 64'd0);
        do_op(1'b1, 32'h304, 32'h0, 4'hF, 2, 1, 32'h55AA55AA);

`ifdef DMEM_STORE_POST_EN
        // Posted store followed by a load
        memWrite = 1'b1; memRead = 1'b0; addr = 32'h400; wdata = 32'hA5A5A5A5; byteEn = 4'hF;
        #1;
        chk_eq("post_store_nostall", 64'(stall_mem), 64'd0);
        @(negedge clk);
        memWrite = 1'b0; memRead = 1'b1; addr = 32'h404;
        #1;
        chk_eq("post_load_stall", 64'(stall_mem), 64'd1);
        chk_eq("post_store_req", 64'({dmem_req, dmem_we}), 64'd3);
        chk_eq("post_store_addr", 64'(dmem_addr), 64'h400);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #1;
        chk_eq("post_done_stall", 64'(stall_mem), 64'd1);
        @(negedge clk);
        #1;
        chk_eq("post_idle_stall", 64'(stall_mem), 64'd1);
        @(negedge clk);
        #1;
        chk_eq("post_load_req", 64'({dmem_req, dmem_we}), 64'd2);
        chk_eq("post_load_addr", 64'(dmem_addr), 64'h404);
        ready = 1'b1; rvalid = 1'b1; rdata = 32'h13572468;
        @(negedge clk);
        ready = 1'b0; rvalid = 1'b0;
        #1;
        model_rst = 32'h13572468;
        chk_eq("post_load_release", 64'(stall_mem), 64'd0);
        chk_eq("post_load_rdata", 64'(memReadRst), 64'(model_rst));
        memRead = 1'b0;
        @(negedge clk);
`endif

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            bit ld;
`ifdef DMEM_STORE_POST_EN
            ld = 1'b1;
`else
            ld = 1'($urandom_range(0, 1));
`endif
            do_op(ld, $urandom, $urandom, 4'($urandom), $urandom_range(0, 6),
                  $urandom_range(0, 7), $urandom);
            idle_cycles($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
